cpu_control_sequencer: RTL

Hardwired control unit for the ALU system datapath: drives every datapath control input, fetches 16-bit instructions byte by byte through the instruction register, decodes them and sequences execution using the IR contents and ALU flags. It is the initiator of the datapath control interface; the datapath only responds. Every instruction takes four cycles. Halts on HLT.

---
 rtl/cpu_ctrl_pkg.sv | 86 ++++++++
 rtl/cpu_exec_decoder.sv | 69 ++++++
 rtl/cpu_control_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired CPU control unit: FSM states, opcodes,
// datapath function codes and the idle control vector.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH_L,
    ST_FETCH_H,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ALU = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_BEQ = 4'd4;
  localparam logic [3:0] OP_LD  = 4'd5;
  localparam logic [3:0] OP_ST  = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;

  localparam logic [2:0] FUN_HOLD = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [4:0] ALU_PASSA = 5'b10000;

  localparam logic [1:0] OUTD_PC = 2'b00;
  localparam logic [1:0] OUTD_AR = 2'b01;

  localparam logic [2:0] ARF_SEL_PC = 3'b100;

  typedef struct packed {
    logic [2:0] rfOutASel;
    logic [2:0] rfOutBSel;
    logic [2:0] rfFunSel;
    logic [3:0] rfRegSel;
    logic [3:0] rfScrSel;
    logic [4:0] aluFunSel;
    logic       aluWf;
    logic [1:0] arfOutCSel;
    logic [1:0] arfOutDSel;
    logic [2:0] arfFunSel;
    logic [2:0] arfRegSel;
    logic       irLh;
    logic       irWrite;
    logic       memWr;
    logic       memCs;
    logic [1:0] muxASel;
    logic [1:0] muxBSel;
    logic       muxCSel;
  } ctrl_t;

  // Memory chip select is active-low, so idle keeps it high.
  localparam ctrl_t CTRL_IDLE = '{
    rfOutASel:  3'd0,
    rfOutBSel:  3'd0,
    rfFunSel:   FUN_HOLD,
    rfRegSel:   4'd0,
    rfScrSel:   4'd0,
    aluFunSel:  5'd0,
    aluWf:      1'b0,
    arfOutCSel: 2'd0,
    arfOutDSel: OUTD_PC,
    arfFunSel:  FUN_HOLD,
    arfRegSel:  3'd0,
    irLh:       1'b0,
    irWrite:    1'b0,
    memWr:      1'b0,
    memCs:      1'b1,
    muxASel:    2'd0,
    muxBSel:    2'd0,
    muxCSel:    1'b0
  };

  function automatic logic [3:0] regOneHot(input logic [1:0] n);
    return 4'b1000 >> n;
  endfunction

  function automatic logic [2:0] regOutSel(input logic [1:0] n);
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/cpu_exec_decoder.sv
// EXEC-cycle control vector from registered opcode, IR fields and Z flag.
// Purely combinational, zero latency; no backpressure.
module cpu_exec_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [11:0] irField,
  input  logic        zFlag,
  output ctrl_t       ctrl
);

  logic [1:0] rd;
  logic [1:0] ra;
  logic [1:0] rb;

  assign rd = irField[11:10];
  assign ra = irField[9:8];
  assign rb = irField[7:6];

  always_comb begin
    ctrl = CTRL_IDLE;
    case (opcode)
      OP_LDI: begin
        ctrl.muxASel  = 2'b11;
        ctrl.rfFunSel = FUN_LOAD;
        ctrl.rfRegSel = regOneHot(rd);
      end
      OP_ALU: begin
        ctrl.rfOutASel = regOutSel(ra);
        ctrl.rfOutBSel = regOutSel(rb);
        ctrl.aluFunSel = irField[4:0];
        ctrl.aluWf     = 1'b1;
        ctrl.muxASel   = 2'b00;
        ctrl.rfFunSel  = FUN_LOAD;
        ctrl.rfRegSel  = regOneHot(rd);
      end
      OP_BRA: begin
        ctrl.muxBSel   = 2'b11;
        ctrl.arfFunSel = FUN_LOAD;
        ctrl.arfRegSel = ARF_SEL_PC;
      end
      OP_BEQ: begin
        if (zFlag) begin
          ctrl.muxBSel   = 2'b11;
          ctrl.arfFunSel = FUN_LOAD;
          ctrl.arfRegSel = ARF_SEL_PC;
        end
      end
      OP_LD: begin
        ctrl.arfOutDSel = OUTD_AR;
        ctrl.memCs      = 1'b0;
        ctrl.muxASel    = 2'b10;
        ctrl.rfFunSel   = FUN_LOAD;
        ctrl.rfRegSel   = regOneHot(rd);
      end
      OP_ST: begin
        // Store data travels Ra -> ALU pass-through -> MuxC -> memory.
        ctrl.rfOutASel  = regOutSel(ra);
        ctrl.aluFunSel  = ALU_PASSA;
        ctrl.muxCSel    = 1'b0;
        ctrl.arfOutDSel = OUTD_AR;
        ctrl.memCs      = 1'b0;
        ctrl.memWr      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Hardwired control FSM: 4 cycles per instruction (HLT stops at DECODE), outputs combinational
// from state and IROut; no backpressure. Optional CPU_ILLEGAL_TRAP_EN halts on opcodes 8..15.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted
`ifdef CPU_ILLEGAL_TRAP_EN
  ,
  output logic        Illegal
`endif
);

  state_t     state;
  logic [3:0] opcodeQ;
  ctrl_t      execCtrl;
  ctrl_t      ctrl;
  logic       unusedFlags;

  assign unusedFlags = ^FlagsOut[2:0];

`ifdef CPU_ILLEGAL_TRAP_EN
  logic illegalQ;
  assign Illegal = illegalQ;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_RST;
      opcodeQ <= OP_NOP;
`ifdef CPU_ILLEGAL_TRAP_EN
      illegalQ <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RST:     state <= ST_FETCH_L;
        ST_FETCH_L: state <= ST_FETCH_H;
        ST_FETCH_H: state <= ST_DECODE;
        ST_DECODE: begin
          opcodeQ <= IROut[15:12];
          if (IROut[15:12] == OP_HLT) begin
            state <= ST_HALT;
          end
`ifdef CPU_ILLEGAL_TRAP_EN
          else if (IROut[15]) begin
            state    <= ST_HALT;
            illegalQ <= 1'b1;
          end
`endif
          else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC:    state <= ST_FETCH_L;
        ST_HALT:    state <= ST_HALT;
        default:    state <= ST_RST;
      endcase
    end
  end

  cpu_exec_decoder uExecDecoder (
    .opcode  (opcodeQ),
    .irField (IROut[11:0]),
    .zFlag   (FlagsOut[3]),
    .ctrl    (execCtrl)
  );

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_RST: begin
        ctrl.arfRegSel = ARF_SEL_PC;
        ctrl.arfFunSel = FUN_CLR;
      end
      ST_FETCH_L, ST_FETCH_H: begin
        // IR latches the addressed byte while PC steps to the next one.
        ctrl.arfOutDSel = OUTD_PC;
        ctrl.memCs      = 1'b0;
        ctrl.irWrite    = 1'b1;
        ctrl.irLh       = (state == ST_FETCH_H);
        ctrl.arfRegSel  = ARF_SEL_PC;
        ctrl.arfFunSel  = FUN_INC;
      end
      ST_EXEC: ctrl = execCtrl;
      default: ;
    endcase
  end

  assign RF_OutASel  = ctrl.rfOutASel;
  assign RF_OutBSel  = ctrl.rfOutBSel;
  assign RF_FunSel   = ctrl.rfFunSel;
  assign RF_RegSel   = ctrl.rfRegSel;
  assign RF_ScrSel   = ctrl.rfScrSel;
  assign ALU_FunSel  = ctrl.aluFunSel;
  assign ALU_WF      = ctrl.aluWf;
  assign ARF_OutCSel = ctrl.arfOutCSel;
  assign ARF_OutDSel = ctrl.arfOutDSel;
  assign ARF_FunSel  = ctrl.arfFunSel;
  assign ARF_RegSel  = ctrl.arfRegSel;
  assign IR_LH       = ctrl.irLh;
  assign IR_Write    = ctrl.irWrite;
  assign Mem_WR      = ctrl.memWr;
  assign Mem_CS      = ctrl.memCs;
  assign MuxASel     = ctrl.muxASel;
  assign MuxBSel     = ctrl.muxBSel;
  assign MuxCSel     = ctrl.muxCSel;
  assign Halted      = (state == ST_HALT);

endmodule
